// File: rtl/adxl_pkg.sv
// Shared constants, reset values and state type for the ADXL-style SPI responder.
package adxl_pkg;

  localparam logic [7:0] DEVID_DEFAULT = 8'hE5;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  localparam logic [7:0] RST_BW_RATE     = 8'h0A;
  localparam logic [7:0] RST_POWER_CTL   = 8'h00;
  localparam logic [7:0] RST_INT_ENABLE  = 8'h00;
  localparam logic [7:0] RST_DATA_FORMAT = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD,
    ST_WR
  } state_t;

  // True for the six sample-data registers whose reads acknowledge DATA_READY.
  function automatic logic is_data_addr(input logic [5:0] a);
    return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
  endfunction

endpackage

// File: rtl/adxl_spi_responder_spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with rise/fall pulses.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/adxl_spi_responder.sv
// SPI mode-3 responder emulating the accelerometer register interface.
module adxl_spi_responder
  import adxl_pkg::*;
#(
  parameter logic [7:0]  DEVID       = DEVID_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_csn,
  input  logic        spi_sclk,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic        int1,
  output logic [7:0]  cfg_bw_rate,
  output logic [7:0]  cfg_power_ctl,
  output logic [7:0]  cfg_data_format,
  output logic [7:0]  cfg_int_enable
);

  logic csn_lvl, csn_rise, csn_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;
  logic unused_sync;

  // csn resets to "selected" so a frame already in progress at reset release
  // cannot produce a falling edge; a fresh frame needs csn high, then low.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_csn (
    .clk(clk), .reset(reset), .din(spi_csn),
    .level(csn_lvl), .rise(csn_rise), .fall(csn_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(spi_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .reset(reset), .din(spi_sdi),
    .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
  );

  assign unused_sync = sclk_lvl ^ sdi_rise ^ sdi_fall;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_in, shift_out, byte_in, rd_data;
  logic [5:0]  addr;
  logic        mb, load_rd, byte_done;

  logic [7:0]  bw_rate, power_ctl, int_enable, data_format;
  logic [15:0] data_x, data_y, data_z;
  logic [15:0] pend_x, pend_y, pend_z;
  logic        data_ready, pend_valid;

  assign byte_in   = {shift_in[6:0], sdi_lvl};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state_q != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: command byte selects read or write; csn rise always aborts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (csn_fall) state_d = ST_CMD;
      ST_CMD:  if (byte_done) state_d = byte_in[7] ? ST_RD : ST_WR;
      ST_RD:   state_d = ST_RD;
      ST_WR:   state_d = ST_WR;
      default: state_d = ST_IDLE;
    endcase
    if (csn_rise) state_d = ST_IDLE;
  end

  // Register-file read mux for the current address.
  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_DEVID:       rd_data = DEVID;
      ADDR_BW_RATE:     rd_data = bw_rate;
      ADDR_POWER_CTL:   rd_data = power_ctl;
      ADDR_INT_ENABLE:  rd_data = int_enable;
      ADDR_INT_SOURCE:  rd_data = {data_ready, 7'b0};
      ADDR_DATA_FORMAT: rd_data = data_format;
      ADDR_DATAX0:      rd_data = data_x[7:0];
      ADDR_DATAX1:      rd_data = data_x[15:8];
      ADDR_DATAY0:      rd_data = data_y[7:0];
      ADDR_DATAY1:      rd_data = data_y[15:8];
      ADDR_DATAZ0:      rd_data = data_z[7:0];
      ADDR_DATAZ1:      rd_data = data_z[15:8];
      default:          rd_data = '0;
    endcase
  end

  // Input shifter, bit counter and address sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      shift_in <= '0;
      addr     <= '0;
      mb       <= 1'b0;
      load_rd  <= 1'b0;
    end else if (state_q == ST_IDLE || csn_rise) begin
      bit_cnt <= '0;
      load_rd <= 1'b0;
    end else if (sclk_rise) begin
      shift_in <= byte_in;
      bit_cnt  <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        if (state_q == ST_CMD) begin
          addr    <= byte_in[5:0];
          mb      <= byte_in[6];
          load_rd <= byte_in[7];
        end else begin
          if (mb) addr <= addr + 6'd1;
          load_rd <= (state_q == ST_RD);
        end
      end
    end else if (sclk_fall && state_q == ST_RD) begin
      load_rd <= 1'b0;
    end
  end

  // SDO shifter: a pending byte load happens on the first falling edge after
  // each completed byte, otherwise the next bit is shifted out.
  always_ff @(posedge clk) begin
    if (reset) begin
      spi_sdo    <= 1'b0;
      spi_sdo_oe <= 1'b0;
      shift_out  <= '0;
    end else if (csn_rise) begin
      spi_sdo    <= 1'b0;
      spi_sdo_oe <= 1'b0;
    end else if (sclk_fall && state_q == ST_RD) begin
      if (load_rd) begin
        spi_sdo    <= rd_data[7];
        shift_out  <= {rd_data[6:0], 1'b0};
        spi_sdo_oe <= 1'b1;
      end else begin
        spi_sdo   <= shift_out[7];
        shift_out <= {shift_out[6:0], 1'b0};
      end
    end
  end

  // Register file, sample capture with pending buffer, DATA_READY and int1.
  // Assignment order gives sample loads (set) priority over the read clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      bw_rate     <= RST_BW_RATE;
      power_ctl   <= RST_POWER_CTL;
      int_enable  <= RST_INT_ENABLE;
      data_format <= RST_DATA_FORMAT;
      data_x      <= '0;
      data_y      <= '0;
      data_z      <= '0;
      pend_x      <= '0;
      pend_y      <= '0;
      pend_z      <= '0;
      pend_valid  <= 1'b0;
      data_ready  <= 1'b0;
      int1        <= 1'b0;
    end else begin
      int1 <= data_ready & int_enable[7];
      if (state_q == ST_WR && byte_done && !csn_rise) begin
        case (addr)
          ADDR_BW_RATE:     bw_rate     <= byte_in;
          ADDR_POWER_CTL:   power_ctl   <= byte_in;
          ADDR_INT_ENABLE:  int_enable  <= byte_in;
          ADDR_DATA_FORMAT: data_format <= byte_in;
          default: ;
        endcase
      end
      if (state_q == ST_RD && byte_done && is_data_addr(addr)) data_ready <= 1'b0;
      if (csn_rise && pend_valid) begin
        data_x     <= pend_x;
        data_y     <= pend_y;
        data_z     <= pend_z;
        data_ready <= 1'b1;
        pend_valid <= 1'b0;
      end
      if (sample_valid) begin
        if (csn_lvl) begin
          data_x     <= sample_x;
          data_y     <= sample_y;
          data_z     <= sample_z;
          data_ready <= 1'b1;
          pend_valid <= 1'b0;
        end else begin
          pend_x     <= sample_x;
          pend_y     <= sample_y;
          pend_z     <= sample_z;
          pend_valid <= 1'b1;
        end
      end
    end
  end

  assign cfg_bw_rate     = bw_rate;
  assign cfg_power_ctl   = power_ctl;
  assign cfg_data_format = data_format;
  assign cfg_int_enable  = int_enable;

endmodule

// File: tb/tb_adxl_spi_responder.sv
// Self-checking bench: drives SPI frames as the initiator and compares every
// response against a register-level model of the sensor.
module tb_adxl_spi_responder;

  localparam int HALF = 8;  // clk cycles per SCLK half period

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_csn, spi_sclk, spi_sdi;
  logic        spi_sdo, spi_sdo_oe;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        sample_valid;
  logic        int1;
  logic [7:0]  cfg_bw_rate, cfg_power_ctl, cfg_data_format, cfg_int_enable;

  always #5 clk = ~clk;

  adxl_spi_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .sample_valid(sample_valid), .int1(int1),
    .cfg_bw_rate(cfg_bw_rate), .cfg_power_ctl(cfg_power_ctl),
    .cfg_data_format(cfg_data_format), .cfg_int_enable(cfg_int_enable)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_bw, m_pwr, m_ie, m_df;
  logic [15:0] m_x, m_y, m_z, p_x, p_y, p_z;
  logic        m_dr, m_pend;

  task automatic model_reset();
    m_bw = 8'h0A; m_pwr = 8'h00; m_ie = 8'h00; m_df = 8'h00;
    m_x = '0; m_y = '0; m_z = '0; p_x = '0; p_y = '0; p_z = '0;
    m_dr = 1'b0; m_pend = 1'b0;
  endtask

  function automatic logic [7:0] m_read(input logic [5:0] a);
    case (a)
      6'h00: return 8'hE5;
      6'h2C: return m_bw;
      6'h2D: return m_pwr;
      6'h2E: return m_ie;
      6'h30: return {m_dr, 7'b0};
      6'h31: return m_df;
      6'h32: return m_x[7:0];
      6'h33: return m_x[15:8];
      6'h34: return m_y[7:0];
      6'h35: return m_y[15:8];
      6'h36: return m_z[7:0];
      6'h37: return m_z[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_write(input logic [5:0] a, input logic [7:0] d);
    case (a)
      6'h2C: m_bw  = d;
      6'h2D: m_pwr = d;
      6'h2E: m_ie  = d;
      6'h31: m_df  = d;
      default: ;
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  logic [7:0]  tx [8];
  logic [7:0]  rx [8];
  logic [15:0] nx, ny, nz;

  task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sample_x = x; sample_y = y; sample_z = z; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    if (spi_csn) begin
      m_x = x; m_y = y; m_z = z; m_dr = 1'b1; m_pend = 1'b0;
    end else begin
      p_x = x; p_y = y; p_z = z; m_pend = 1'b1;
    end
  endtask

  // Shift nbits of b (MSB first); capture sdo/oe just before each rising edge.
  task automatic spi_bits(input logic [7:0] b, input int nbits,
                          output logic [7:0] r, output logic [7:0] o);
    r = '0; o = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_sclk = 1'b0; spi_sdi = b[7-i];
      repeat (HALF) @(posedge clk);
      #1;
      r[7-i] = spi_sdo; o[7-i] = spi_sdo_oe;
      spi_sclk = 1'b1;
      repeat (HALF) @(posedge clk);
    end
  endtask

  task automatic end_frame();
    repeat (HALF) @(posedge clk);
    spi_csn = 1'b1;
    if (m_pend) begin
      m_x = p_x; m_y = p_y; m_z = p_z; m_dr = 1'b1; m_pend = 1'b0;
    end
    repeat (2*HALF) @(posedge clk);
    #1;
  endtask

  task automatic check_cfg(input string tag);
    check({tag, " bw_rate"},     cfg_bw_rate,     m_bw);
    check({tag, " power_ctl"},   cfg_power_ctl,   m_pwr);
    check({tag, " int_enable"},  cfg_int_enable,  m_ie);
    check({tag, " data_format"}, cfg_data_format, m_df);
    check({tag, " int1"},        int1,            m_dr & m_ie[7]);
  endtask

  // Full frame: command + n data bytes from tx[]; read bytes land in rx[].
  task automatic frame(input logic [7:0] cmd, input int n, input int strobe_at, input string tag);
    logic [7:0] r, o, exp;
    logic [5:0] a;
    spi_csn = 1'b0;
    repeat (HALF) @(posedge clk);
    spi_bits(cmd, 8, r, o);
    check({tag, " cmd oe"}, o, 8'h00);
    a = cmd[5:0];
    for (int i = 0; i < n; i++) begin
      exp = m_read(a);
      spi_bits(tx[i], 8, r, o);
      rx[i] = r;
      if (cmd[7]) begin
        check($sformatf("%s rd%0d @%0h", tag, i, a), r, exp);
        check($sformatf("%s oe%0d", tag, i), o, 8'hFF);
        if (a >= 6'h32 && a <= 6'h37) m_dr = 1'b0;
      end else begin
        check($sformatf("%s wr oe%0d", tag, i), o, 8'h00);
        m_write(a, tx[i]);
      end
      if (cmd[6]) a = a + 6'd1;
      if (i == strobe_at) strobe(nx, ny, nz);
    end
    end_frame();
    check({tag, " oe after"}, spi_sdo_oe, 1'b0);
    check_cfg(tag);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r, o;
    logic [5:0] ra;
    logic [7:0] rd;
    reset = 1'b1; spi_csn = 1'b1; spi_sclk = 1'b1; spi_sdi = 1'b0;
    sample_x = '0; sample_y = '0; sample_z = '0; sample_valid = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin tx[i] = '0; rx[i] = '0; end
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    // reset state
    check("rst sdo", spi_sdo, 1'b0);
    check("rst oe", spi_sdo_oe, 1'b0);
    check("rst int1", int1, 1'b0);
    check("rst bw_rate", cfg_bw_rate, 8'h0A);
    check_cfg("rst");

    // DEVID read
    tx[0] = 8'h00;
    frame(8'h80, 1, -1, "devid");
    check("devid value", rx[0], 8'hE5);

    // write/read-back of POWER_CTL
    tx[0] = 8'h08;
    frame(8'h2D, 1, -1, "wr pwr");
    check("pwr cfg", cfg_power_ctl, 8'h08);
    frame(8'hAD, 1, -1, "rd pwr");
    check("pwr readback", rx[0], 8'h08);

    // multi-byte sample read
    strobe(16'h1234, 16'hFF80, 16'h0100);
    repeat (4) @(posedge clk);
    frame(8'hF2, 6, -1, "mb samples");
    check("mb b0", rx[0], 8'h34); check("mb b1", rx[1], 8'h12);
    check("mb b2", rx[2], 8'h80); check("mb b3", rx[3], 8'hFF);
    check("mb b4", rx[4], 8'h00); check("mb b5", rx[5], 8'h01);

    // coherency: strobe mid-frame, new data only in the next frame
    nx = 16'($urandom); ny = 16'($urandom); nz = 16'($urandom);
    frame(8'hF2, 6, 2, "coh old");
    check("coh old x0", rx[0], 8'h34);
    frame(8'hF2, 6, -1, "coh new");
    check("coh new z1", rx[5], nz[15:8]);

    // interrupt
    tx[0] = 8'h80;
    frame(8'h2E, 1, -1, "wr ie");
    strobe(16'($urandom), 16'($urandom), 16'($urandom));
    repeat (6) @(posedge clk);
    #1;
    check("int1 set", int1, 1'b1);
    check_cfg("int set");
    frame(8'hB2, 1, -1, "int clr");
    check("int1 cleared", int1, 1'b0);

    // abort mid write byte
    spi_csn = 1'b0;
    repeat (HALF) @(posedge clk);
    spi_bits(8'h2C, 8, r, o);
    spi_bits(8'h55, 4, r, o);
    end_frame();
    check("abort bw_rate", cfg_bw_rate, 8'h0A);
    check_cfg("abort");

    // MB read wrapping 0x3F -> 0x00
    frame(8'hFF, 2, -1, "wrap");
    check("wrap b0", rx[0], 8'h00);
    check("wrap b1", rx[1], 8'hE5);

    // randomized writes (single and MB/non-MB pairs) with read-back
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 4))
        0: ra = 6'h2C;
        1: ra = 6'h2D;
        2: ra = 6'h2E;
        3: ra = 6'h31;
        default: ra = 6'($urandom);
      endcase
      tx[0] = 8'($urandom); tx[1] = 8'($urandom);
      frame({1'b0, 1'($urandom), ra}, 2, -1, $sformatf("rnd wr%0d", k));
      if ($urandom_range(0, 1) == 1)
        strobe(16'($urandom), 16'($urandom), 16'($urandom));
      frame({2'b11, ra}, 2, -1, $sformatf("rnd rd%0d", k));
    end

    // reset mid-frame: remainder of frame must be ignored
    spi_csn = 1'b0;
    repeat (HALF) @(posedge clk);
    spi_bits(8'h2D, 3, r, o);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    rd = 8'h2D << 3;
    spi_bits(rd, 5, r, o);
    spi_bits(8'hFF, 8, r, o);
    end_frame();
    check("midrst pwr", cfg_power_ctl, 8'h00);
    check_cfg("midrst");
    tx[0] = 8'h00;
    frame(8'h80, 1, -1, "post rst devid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
